bcd_conv_arbiter: RTL

Shares a single iterative binary-to-BCD engine between two requesters. The engine uses shift-and-add-3 (double dabble) and processes one input bit per clock. The block arbitrates requests, captures the winner's operand, and sequences DATA_W shift cycles. It presents the packed BCD result with the requester ID under a valid/ready handshake. It sits between two producers of unsigned binary values (e.g. counters feeding display drivers) and the display/output path.

---
 rtl/bcd_conv_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_conv_arbiter
// Purpose  : Two-requester arbiter sharing one iterative double-dabble
//            binary-to-BCD engine (one operand bit per clock). The result is
//            presented with the owning requester ID on a valid/ready port.
// Options  : BCD_ARB_ROUND_ROBIN_EN - defined: round-robin on contention;
//            undefined: fixed priority, requester 0 wins.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_i,
  input  logic [DATA_W-1:0]     datain0_i,
  output logic                  ack0_o,
  input  logic                  req1_i,
  input  logic [DATA_W-1:0]     datain1_i,
  output logic                  ack1_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   dataout_o,
  output logic                  out_id_o,
  output logic                  busy_o,
  output logic [15:0]           conv_count_o
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  opnd_q, opnd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               id_q, id_d;
  logic [15:0]        conv_count_q, conv_count_d;
  logic               grant1;

  // Add-3 correction: every digit is judged on its pre-adjust value
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign acc_adj[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5) ? (acc_q[4*g +: 4] + 4'd3)
                                                          : acc_q[4*g +: 4];
  end

`ifdef BCD_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Requester 1 wins a tie only if requester 0 was granted last
  assign grant1 = req1_i & (~req0_i | ~last_q);

  // Remember the most recent grant, updated on every capture
  always_comb begin
    last_d = last_q;
    if ((state_q == IDLE) && (req0_i || req1_i)) begin
      last_d = grant1;
    end
  end

  // Last-grant register; reset value lets requester 0 win the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is idle
  assign grant1 = req1_i & ~req0_i;
`endif

  // Next-state and datapath: capture, shift-and-add-3, present result
  always_comb begin
    state_d      = state_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    id_d         = id_q;
    conv_count_d = conv_count_q;
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          id_d    = grant1;
          opnd_d  = grant1 ? datain1_i : datain0_i;
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = {acc_adj[ACC_W-2:0], opnd_q[DATA_W-1]};
        opnd_d = {opnd_q[DATA_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          conv_count_d = conv_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      opnd_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      id_q         <= 1'b0;
      conv_count_q <= '0;
    end else begin
      state_q      <= state_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      id_q         <= id_d;
      conv_count_q <= conv_count_d;
    end
  end

  assign ack0_o       = ack0_q;
  assign ack1_o       = ack1_q;
  assign out_valid_o  = (state_q == DONE);
  assign dataout_o    = acc_q;
  assign out_id_o     = id_q;
  assign busy_o       = (state_q != IDLE);
  assign conv_count_o = conv_count_q;

endmodule
`default_nettype wire
